hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller that drives the IF/ID and ID/EX pipeline registers and the PC register.
- Generates per-stage enables (stall) and active-low flush strobes, which connect directly to the `i_enable_*` and `i_reset_*` inputs of those registers.
- Handles three events: load-use stalls, EX-stage redirects (taken branch or jump) with a configurable flush window, and data-memory wait freezes.
- A redirect that arrives during a freeze is held until the freeze ends.

Parameters:
- FLUSH_CYCLES, 1: cycles the IF/ID flush is held after a redirect (1..15); covers fetch latency.
- CNT_W, 4: width of the flush-window counter.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_reset  in  1  synchronous reset, active-high.
- i_id_rs1_addr  in  5  rs1 of the instruction in ID.
- i_id_rs2_addr  in  5  rs2 of the instruction in ID.
- i_id_rs1_used  in  1  ID instruction reads rs1.
- i_id_rs2_used  in  1  ID instruction reads rs2.
- i_ex_rd_addr  in  5  rd of the instruction in EX.
- i_ex_rd_wren  in  1  EX instruction writes rd.
- i_ex_mem_rden  in  1  EX instruction is a load.
- i_ex_redirect  in  1  one-cycle pulse: EX resolved a taken branch or jump; the PC mux selects the target this cycle.
- i_mem_busy  in  1  data memory not ready; the whole pipe must freeze.
- o_enable_pc  out  1  PC register load enable.
- o_enable_if  out  1  IF/ID register enable.
- o_reset_if  out  1  IF/ID flush, active-low (0 = load NOP 0x00000013).
- o_enable_id  out  1  ID/EX register enable.
- o_reset_id  out  1  ID/EX flush, active-low (0 = bubble).

Behaviour:
- Output timing: outputs are combinational (Mealy) from the registered state plus the current inputs. State, the counter and the pending flag are registered.
- States: RUN, MEM_WAIT, FLUSH. Registered values: state, cnt[CNT_W-1:0], pend_redirect.
- Default outputs in RUN with no event: all enables = 1, o_reset_if = 1, o_reset_id = 1.
- Load-use condition: lu = i_ex_mem_rden & i_ex_rd_wren & (i_ex_rd_addr != 0) & ((i_id_rs1_used & rs1 == rd) | (i_id_rs2_used & rs2 == rd)).
- RUN, priority order:
  1. i_mem_busy: all enables = 0, both flushes inactive. Next state MEM_WAIT; pend_redirect <= i_ex_redirect.
  2. i_ex_redirect: enables = 1, o_reset_if = 0, o_reset_id = 0. If FLUSH_CYCLES > 1: go to FLUSH with cnt = FLUSH_CYCLES - 1.
  3. lu: o_enable_pc = 0, o_enable_if = 0, o_enable_id = 1, o_reset_id = 0 (one bubble). Stay in RUN; the hazard clears next cycle.
- MEM_WAIT:
  - While i_mem_busy: freeze (all enables = 0, flushes inactive). pend_redirect |= i_ex_redirect.
  - On the first cycle with i_mem_busy = 0: if pend_redirect or i_ex_redirect, apply the redirect outputs exactly as in RUN step 2 and clear pend_redirect. Otherwise evaluate lu exactly as in RUN. Next state is RUN, or FLUSH per the FLUSH_CYCLES rule.
- FLUSH:
  - Default: enables = 1, o_reset_if = 0, o_reset_id = 0; cnt decrements; leave for RUN when cnt reaches 0.
  - New i_ex_redirect: reload cnt = FLUSH_CYCLES - 1.
  - i_mem_busy: freeze with flushes inactive (a flush must not override a frozen register); cnt and state held.
  - lu is ignored in FLUSH (the ID instruction is being killed).
- Reset: while i_reset = 1, all enables = 0 and o_reset_if = o_reset_id = 0. On exit from reset: state = RUN, cnt = 0, pend_redirect = 0.
- Boundaries:
  - rd = x0 never stalls.
  - Both rs1 and rs2 matching still gives a single bubble.
  - Redirect and lu in the same cycle: redirect wins (no stall).
  - Reset mid-FLUSH or mid-MEM_WAIT drops any pending redirect.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- With the macro defined, the block adds outputs o_lu_stall_cnt[31:0], o_flush_cnt[31:0] and o_mem_wait_cnt[31:0]:
  - o_lu_stall_cnt increments on each load-use bubble cycle.
  - o_flush_cnt increments on each applied redirect; a reload inside FLUSH also counts.
  - o_mem_wait_cnt increments on each freeze cycle.
  - All three saturate at 0xFFFFFFFF and reset to 0.
- Without the macro, these ports and counters are absent; core behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - the state enum (RUN, MEM_WAIT, FLUSH);
  - REG_X0 = 5'd0;
  - NOP_INSTR = 32'h0000_0013 (shared with the pipeline registers).
- Sub-module hz_sat_cnt: a 32-bit saturating counter with inc and synchronous reset, instantiated 3x only under HAZARD_PERF_EN.

Test Plan:
- Load-use: EX lw x5, ID add x6,x5,x7 (rs1_used = 1) -> exactly 1 cycle with o_enable_pc = 0, o_enable_if = 0, o_reset_id = 0; next cycle all default.
- rd = x0: EX lw x0, ID reads x0 -> no stall, outputs default.
- Redirect with FLUSH_CYCLES = 3: i_ex_redirect pulse at cycle t -> o_reset_if = 0 at t, t+1, t+2; back to 1 at t+3; enables 1 throughout.
- Redirect during freeze: i_mem_busy high 4 cycles, redirect pulse in the 2nd -> enables 0 and flushes 1 for 4 cycles; the flush is applied in the cycle busy drops.
- Simultaneous: redirect + lu in the same cycle -> no stall, flush applied. Also: busy asserted mid-FLUSH -> cnt held, flush deasserted until busy drops.
- Reset mid-FLUSH (i_reset for 2 cycles) -> enables 0 and flushes 0 during reset; RUN defaults the cycle after; with HAZARD_PERF_EN, all counters read 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and the
// pipeline registers it drives.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } hz_state_t;

  localparam logic [4:0]  REG_X0    = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of hazard-detection inputs and pipeline-control outputs.
// slave = hazard controller side, master = pipeline side.
interface hazard_ctrl_if;
  logic [4:0] i_id_rs1_addr;
  logic [4:0] i_id_rs2_addr;
  logic       i_id_rs1_used;
  logic       i_id_rs2_used;
  logic [4:0] i_ex_rd_addr;
  logic       i_ex_rd_wren;
  logic       i_ex_mem_rden;
  logic       i_ex_redirect;
  logic       i_mem_busy;
  logic       o_enable_pc;
  logic       o_enable_if;
  logic       o_reset_if;
  logic       o_enable_id;
  logic       o_reset_id;

  modport slave (
    input  i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used, i_id_rs2_used,
    input  i_ex_rd_addr, i_ex_rd_wren, i_ex_mem_rden, i_ex_redirect, i_mem_busy,
    output o_enable_pc, o_enable_if, o_reset_if, o_enable_id, o_reset_id
  );

  modport master (
    output i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used, i_id_rs2_used,
    output i_ex_rd_addr, i_ex_rd_wren, i_ex_mem_rden, i_ex_redirect, i_mem_busy,
    input  o_enable_pc, o_enable_if, o_reset_if, o_enable_id, o_reset_id
  );
endinterface

// File: rtl/hz_sat_cnt.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module hz_sat_cnt (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_inc,
  output logic [31:0] o_cnt
);
  logic [31:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect flush window and
// memory-wait freeze. Define HAZARD_PERF_EN to add saturating event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] o_lu_stall_cnt,
  output logic [31:0] o_flush_cnt,
  output logic [31:0] o_mem_wait_cnt
`endif
);

  hz_state_t        r_state;
  hz_state_t        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_pend;
  logic             w_pend_next;
  logic             w_lu;
  logic             w_freeze;
  logic             w_apply;
  logic             w_flush_hold;
  logic             w_bubble;

  assign w_lu = hz.i_ex_mem_rden && hz.i_ex_rd_wren && (hz.i_ex_rd_addr != REG_X0) &&
                ((hz.i_id_rs1_used && (hz.i_id_rs1_addr == hz.i_ex_rd_addr)) ||
                 (hz.i_id_rs2_used && (hz.i_id_rs2_addr == hz.i_ex_rd_addr)));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_pend  <= w_pend_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pend_next  = r_pend;
    w_freeze     = 1'b0;
    w_apply      = 1'b0;
    w_flush_hold = 1'b0;
    w_bubble     = 1'b0;
    case (r_state)
      RUN: begin
        if (hz.i_mem_busy) begin
          w_freeze     = 1'b1;
          w_state_next = MEM_WAIT;
          w_pend_next  = hz.i_ex_redirect;
        end else if (hz.i_ex_redirect) begin
          w_apply = 1'b1;
        end else if (w_lu) begin
          w_bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (hz.i_mem_busy) begin
          w_freeze    = 1'b1;
          w_pend_next = r_pend | hz.i_ex_redirect;
        end else begin
          w_state_next = RUN;
          w_pend_next  = 1'b0;
          if (r_pend || hz.i_ex_redirect) begin
            w_apply = 1'b1;
          end else if (w_lu) begin
            w_bubble = 1'b1;
          end
        end
      end
      FLUSH: begin
        // A redirect seen while frozen here is parked and replayed on thaw.
        if (hz.i_mem_busy) begin
          w_freeze    = 1'b1;
          w_pend_next = r_pend | hz.i_ex_redirect;
        end else if (r_pend || hz.i_ex_redirect) begin
          w_apply     = 1'b1;
          w_pend_next = 1'b0;
        end else begin
          w_flush_hold = 1'b1;
          w_cnt_next   = r_cnt - CNT_W'(1);
          if (r_cnt <= CNT_W'(1)) begin
            w_state_next = RUN;
          end
        end
      end
      default: w_state_next = RUN;
    endcase
    if (w_apply) begin
      if (FLUSH_CYCLES > 1) begin
        w_state_next = FLUSH;
        w_cnt_next   = CNT_W'(FLUSH_CYCLES - 1);
      end else begin
        w_state_next = RUN;
      end
    end
  end

  always_comb begin
    hz.o_enable_pc = 1'b1;
    hz.o_enable_if = 1'b1;
    hz.o_reset_if  = 1'b1;
    hz.o_enable_id = 1'b1;
    hz.o_reset_id  = 1'b1;
    if (i_reset) begin
      hz.o_enable_pc = 1'b0;
      hz.o_enable_if = 1'b0;
      hz.o_reset_if  = 1'b0;
      hz.o_enable_id = 1'b0;
      hz.o_reset_id  = 1'b0;
    end else if (w_freeze) begin
      hz.o_enable_pc = 1'b0;
      hz.o_enable_if = 1'b0;
      hz.o_enable_id = 1'b0;
    end else if (w_apply || w_flush_hold) begin
      hz.o_reset_if = 1'b0;
      hz.o_reset_id = 1'b0;
    end else if (w_bubble) begin
      hz.o_enable_pc = 1'b0;
      hz.o_enable_if = 1'b0;
      hz.o_reset_id  = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [2:0]  w_perf_inc;
  logic [31:0] w_perf_cnt [3];

  assign w_perf_inc = {w_freeze, w_apply, w_bubble};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_perf
      hz_sat_cnt u_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (w_perf_inc[gi]),
        .o_cnt   (w_perf_cnt[gi])
      );
    end
  endgenerate

  assign o_lu_stall_cnt = w_perf_cnt[0];
  assign o_flush_cnt    = w_perf_cnt[1];
  assign o_mem_wait_cnt = w_perf_cnt[2];
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl: two instances (FLUSH_CYCLES 1 and 3)
// checked every cycle against a cycle-level behavioural model.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       busy = 1'b0, redir = 1'b0, ex_ld = 1'b0, ex_wr = 1'b0;
  logic       use1 = 1'b0, use2 = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;

  hazard_ctrl_if if_a ();
  hazard_ctrl_if if_b ();

  assign if_a.i_id_rs1_addr = rs1;   assign if_b.i_id_rs1_addr = rs1;
  assign if_a.i_id_rs2_addr = rs2;   assign if_b.i_id_rs2_addr = rs2;
  assign if_a.i_id_rs1_used = use1;  assign if_b.i_id_rs1_used = use1;
  assign if_a.i_id_rs2_used = use2;  assign if_b.i_id_rs2_used = use2;
  assign if_a.i_ex_rd_addr  = rd;    assign if_b.i_ex_rd_addr  = rd;
  assign if_a.i_ex_rd_wren  = ex_wr; assign if_b.i_ex_rd_wren  = ex_wr;
  assign if_a.i_ex_mem_rden = ex_ld; assign if_b.i_ex_mem_rden = ex_ld;
  assign if_a.i_ex_redirect = redir; assign if_b.i_ex_redirect = redir;
  assign if_a.i_mem_busy    = busy;  assign if_b.i_mem_busy    = busy;

`ifdef HAZARD_PERF_EN
  logic [31:0] lu_cnt_a, fl_cnt_a, mw_cnt_a, lu_cnt_b, fl_cnt_b, mw_cnt_b;
`endif

  hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) u_dut_a (
    .i_clk   (clk),
    .i_reset (rst),
    .hz      (if_a)
`ifdef HAZARD_PERF_EN
    ,
    .o_lu_stall_cnt (lu_cnt_a),
    .o_flush_cnt    (fl_cnt_a),
    .o_mem_wait_cnt (mw_cnt_a)
`endif
  );

  hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) u_dut_b (
    .i_clk   (clk),
    .i_reset (rst),
    .hz      (if_b)
`ifdef HAZARD_PERF_EN
    ,
    .o_lu_stall_cnt (lu_cnt_b),
    .o_flush_cnt    (fl_cnt_b),
    .o_mem_wait_cnt (mw_cnt_b)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model: remaining flush cycles and a parked redirect per instance, plus
  // event tallies for the optional counters.
  int          m_fc [2] = '{1, 3};
  int          m_left [2];
  bit          m_pend [2];
  int unsigned m_lu [2], m_fl [2], m_mw [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] dut_outs(input int k);
    if (k == 0)
      return {if_a.o_enable_pc, if_a.o_enable_if, if_a.o_reset_if, if_a.o_enable_id, if_a.o_reset_id};
    return {if_b.o_enable_pc, if_b.o_enable_if, if_b.o_reset_if, if_b.o_enable_id, if_b.o_reset_id};
  endfunction

  // One clock cycle: apply inputs after the falling edge, check, advance model.
  task automatic drive(input bit r, input bit b, input bit x, input bit ld, input bit wr,
                       input logic [4:0] d, input bit a1, input logic [4:0] s1,
                       input bit a2, input logic [4:0] s2);
    logic [4:0] exp;
    bit         hazard;
    bit         now;
    @(negedge clk);
    rst = r; busy = b; redir = x; ex_ld = ld; ex_wr = wr;
    rd = d; use1 = a1; rs1 = s1; use2 = a2; rs2 = s2;
    #1;
    hazard = ld && wr && (d != 5'd0) && ((a1 && s1 == d) || (a2 && s2 == d));
`ifdef HAZARD_PERF_EN
    check_val($sformatf("c%0d_lu_cnt_fc1", cyc), lu_cnt_a, m_lu[0]);
    check_val($sformatf("c%0d_fl_cnt_fc1", cyc), fl_cnt_a, m_fl[0]);
    check_val($sformatf("c%0d_mw_cnt_fc1", cyc), mw_cnt_a, m_mw[0]);
    check_val($sformatf("c%0d_lu_cnt_fc3", cyc), lu_cnt_b, m_lu[1]);
    check_val($sformatf("c%0d_fl_cnt_fc3", cyc), fl_cnt_b, m_fl[1]);
    check_val($sformatf("c%0d_mw_cnt_fc3", cyc), mw_cnt_b, m_mw[1]);
`endif
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        exp = 5'b00000;
        m_left[k] = 0; m_pend[k] = 1'b0;
        m_lu[k] = 0; m_fl[k] = 0; m_mw[k] = 0;
      end else if (b) begin
        exp = 5'b00101;
        m_pend[k] = m_pend[k] | x;
        m_mw[k]++;
      end else begin
        now = x | m_pend[k];
        m_pend[k] = 1'b0;
        if (now) begin
          exp = 5'b11010;
          m_left[k] = m_fc[k] - 1;
          m_fl[k]++;
        end else if (m_left[k] > 0) begin
          exp = 5'b11010;
          m_left[k]--;
        end else if (hazard) begin
          exp = 5'b00110;
          m_lu[k]++;
        end else begin
          exp = 5'b11111;
        end
      end
      check_val($sformatf("c%0d_outs_fc%0d", cyc, m_fc[k]), {27'd0, dut_outs(k)}, {27'd0, exp});
    end
    $display("cyc %0d rst=%0b busy=%0b redir=%0b lu=%0b fc1=%b fc3=%b",
             cyc, r, b, x, hazard, dut_outs(0), dut_outs(1));
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
  endtask

  initial begin
    // reset
    drive(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    drive(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    idle(1);
    // load-use: lw x5 in EX, add x6,x5,x7 in ID
    drive(0, 0, 0, 1, 1, 5'd5, 1, 5'd5, 1, 5'd7);
    idle(1);
    // rd = x0 never stalls
    drive(0, 0, 0, 1, 1, 5'd0, 1, 5'd0, 1, 5'd0);
    // both sources match
    drive(0, 0, 0, 1, 1, 5'd9, 1, 5'd9, 1, 5'd9);
    idle(1);
    // redirect pulse, flush window
    drive(0, 0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    idle(4);
    // freeze 4 cycles with redirect in the 2nd
    drive(0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    drive(0, 1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    drive(0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    drive(0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    idle(4);
    // redirect and load-use together
    drive(0, 0, 1, 1, 1, 5'd3, 1, 5'd3, 0, 5'd0);
    idle(3);
    // busy in the middle of a flush window
    drive(0, 0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    drive(0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    drive(0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    idle(3);
    // reset in the middle of a flush window
    drive(0, 0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    drive(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    drive(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    idle(2);
    // reset while a redirect is parked in a freeze
    drive(0, 1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    drive(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    idle(2);
    // randomized traffic over a small register range so hazards are frequent
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)));
    end
    idle(4);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
